// File: rtl/simon_pkg.sv
// Shared definitions for the Simon128/256 round engine: sizes, word/block
// types, the round nonlinearity and the engine state encoding.
package simon_pkg;

  localparam int unsigned SIMON_ROUNDS = 72;
  localparam int unsigned SIMON_WORD_W = 64;
  localparam int unsigned SIMON_KEY_AW = 9;

  typedef logic [SIMON_WORD_W-1:0] simon_word_t;

  // x occupies the upper half of a 128b block, y the lower half
  typedef struct packed {
    simon_word_t x;
    simon_word_t y;
  } simon_block_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } simon_eng_state_e;

  function automatic simon_word_t rol1(input simon_word_t w);
    return {w[SIMON_WORD_W-2:0], w[SIMON_WORD_W-1]};
  endfunction

  function automatic simon_word_t rol2(input simon_word_t w);
    return {w[SIMON_WORD_W-3:0], w[SIMON_WORD_W-1:SIMON_WORD_W-2]};
  endfunction

  function automatic simon_word_t rol8(input simon_word_t w);
    return {w[SIMON_WORD_W-9:0], w[SIMON_WORD_W-1:SIMON_WORD_W-8]};
  endfunction

  // Simon nonlinearity f(x) = (S1 x & S8 x) ^ S2 x
  function automatic simon_word_t simon_f(input simon_word_t w);
    return (rol1(w) & rol8(w)) ^ rol2(w);
  endfunction

endpackage

// File: rtl/simon_round_fn.sv
// One combinational Simon round: x' = y ^ f(x) ^ k, y' = x.
// Ports: x, y  - current state words
//        k     - round key
//        x_next, y_next - state after the round
module simon_round_fn
  import simon_pkg::*;
(
  input  simon_word_t x,
  input  simon_word_t y,
  input  simon_word_t k,
  output simon_word_t x_next,
  output simon_word_t y_next
);

  assign x_next = y ^ simon_f(x) ^ k;
  assign y_next = x;

endmodule

// File: rtl/simon_round_engine.sv
// Iterative Simon128/256 engine, one round per cycle, keys streamed from the
// key-schedule subkey memory (read latency 2). Decryption swaps the halves,
// runs the encrypt round with keys 71..0 and swaps back.
// Ports: clk, rst (sync, active high)
//        in_valid/in_ready/in_decrypt/in_block - block input handshake
//        key_mem_full, key_compute_start       - key schedule status snoop
//        key_rd_en/key_addr, key_data/key_data_vld - subkey memory port
//        out_valid/out_ready/out_block          - result handshake
//        out_abort                              - pulse when a block is dropped
module simon_round_engine
  import simon_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = SIMON_ROUNDS,
  parameter int unsigned WORD_W     = SIMON_WORD_W,
  parameter int unsigned KEY_AW     = SIMON_KEY_AW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_decrypt,
  input  logic [2*WORD_W-1:0]   in_block,
  input  logic                  key_mem_full,
  input  logic                  key_compute_start,
  output logic                  key_rd_en,
  output logic [KEY_AW-1:0]     key_addr,
  input  logic [WORD_W-1:0]     key_data,
  input  logic                  key_data_vld,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*WORD_W-1:0]   out_block,
  output logic                  out_abort
);

  localparam int unsigned CNT_W = $clog2(NUM_ROUNDS + 1);
  localparam logic [CNT_W-1:0] ROUNDS_C = CNT_W'(NUM_ROUNDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ROUNDS - 1);

  simon_eng_state_e state_q, state_d;
  logic             keys_ready_q, keys_ready_d;
  logic             decrypt_q, decrypt_d;
  simon_word_t      x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] rnd_cnt_q, rnd_cnt_d;
  logic             key_rd_en_q, key_rd_en_d;
  logic [KEY_AW-1:0] key_addr_q, key_addr_d;
  logic             out_valid_q, out_valid_d;
  simon_block_t     out_block_q, out_block_d;
  logic             out_abort_q, out_abort_d;
  simon_word_t      x_nx, y_nx;

  // Subkey index for read number idx: forward for encrypt, reversed for decrypt
  function automatic logic [KEY_AW-1:0] key_index(input logic [CNT_W-1:0] idx,
                                                  input logic dec);
    return dec ? KEY_AW'(LAST_IDX - idx) : KEY_AW'(idx);
  endfunction

  simon_round_fn u_round (
    .x      (x_q),
    .y      (y_q),
    .k      (key_data),
    .x_next (x_nx),
    .y_next (y_nx)
  );

  assign in_ready  = (state_q == ST_IDLE) && keys_ready_q;
  assign key_rd_en = key_rd_en_q;
  assign key_addr  = key_addr_q;
  assign out_valid = out_valid_q;
  assign out_block = out_block_q;
  assign out_abort = out_abort_q;

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    decrypt_d    = decrypt_q;
    x_d          = x_q;
    y_d          = y_q;
    issue_cnt_d  = issue_cnt_q;
    rnd_cnt_d    = rnd_cnt_q;
    key_rd_en_d  = 1'b0;
    key_addr_d   = key_addr_q;
    out_valid_d  = out_valid_q;
    out_block_d  = out_block_q;
    out_abort_d  = 1'b0;
    keys_ready_d = keys_ready_q;

    // A new key computation invalidates the stored keys, even on a full pulse
    if (key_compute_start) begin
      keys_ready_d = 1'b0;
    end else if (key_mem_full) begin
      keys_ready_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (in_valid && keys_ready_q) begin
          x_d         = in_decrypt ? in_block[WORD_W-1:0] : in_block[2*WORD_W-1:WORD_W];
          y_d         = in_decrypt ? in_block[2*WORD_W-1:WORD_W] : in_block[WORD_W-1:0];
          decrypt_d   = in_decrypt;
          rnd_cnt_d   = '0;
          // First subkey read is launched on the accept edge itself
          key_rd_en_d = 1'b1;
          key_addr_d  = key_index('0, in_decrypt);
          issue_cnt_d = CNT_W'(1);
          state_d     = ST_RUN;
        end
      end

      ST_RUN: begin
        if (key_compute_start) begin
          out_abort_d = 1'b1;
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          if (issue_cnt_q < ROUNDS_C) begin
            key_rd_en_d = 1'b1;
            key_addr_d  = key_index(issue_cnt_q, decrypt_q);
            issue_cnt_d = issue_cnt_q + CNT_W'(1);
          end
          if (key_data_vld) begin
            x_d = x_nx;
            y_d = y_nx;
            if (rnd_cnt_q != ROUNDS_C) begin
              rnd_cnt_d = rnd_cnt_q + CNT_W'(1);
            end
            if (rnd_cnt_q == LAST_IDX) begin
              out_valid_d   = 1'b1;
              out_block_d.x = decrypt_q ? y_nx : x_nx;
              out_block_d.y = decrypt_q ? x_nx : y_nx;
              state_d       = ST_DONE;
            end
          end
        end
      end

      ST_DONE: begin
        if (key_compute_start) begin
          out_abort_d = 1'b1;
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      keys_ready_q <= 1'b0;
      decrypt_q    <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      issue_cnt_q  <= '0;
      rnd_cnt_q    <= '0;
      key_rd_en_q  <= 1'b0;
      key_addr_q   <= '0;
      out_valid_q  <= 1'b0;
      out_block_q  <= '0;
      out_abort_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      keys_ready_q <= keys_ready_d;
      decrypt_q    <= decrypt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      issue_cnt_q  <= issue_cnt_d;
      rnd_cnt_q    <= rnd_cnt_d;
      key_rd_en_q  <= key_rd_en_d;
      key_addr_q   <= key_addr_d;
      out_valid_q  <= out_valid_d;
      out_block_q  <= out_block_d;
      out_abort_q  <= out_abort_d;
    end
  end

endmodule

// File: tb/tb_simon_round_engine.sv
// Bench for simon_round_engine: subkey memory model (latency 2) fed by a
// Simon128/256 key schedule, expected-result queue and a monitor that pops
// and compares whenever the engine presents a result or an abort.
module tb_simon_round_engine;

  localparam logic [255:0] INIT_KEY =
    256'h1f1e1d1c1b1a1918_1716151413121110_0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [127:0] PT_KAT = 128'h74206e69206d6f6f_6d69732061207369;
  localparam logic [127:0] CT_KAT = 128'h8d2b5579afc8a3a0_3bf72a87efe7b868;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_decrypt;
  logic [127:0] in_block;
  logic         key_mem_full;
  logic         key_compute_start;
  logic         key_rd_en;
  logic [8:0]   key_addr;
  logic [63:0]  key_data;
  logic         key_data_vld;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic         out_abort;

  simon_round_engine dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_decrypt        (in_decrypt),
    .in_block          (in_block),
    .key_mem_full      (key_mem_full),
    .key_compute_start (key_compute_start),
    .key_rd_en         (key_rd_en),
    .key_addr          (key_addr),
    .key_data          (key_data),
    .key_data_vld      (key_data_vld),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_block         (out_block),
    .out_abort         (out_abort)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  logic [63:0] rk [72];

  function automatic logic [63:0] rol(input logic [63:0] w, input int s);
    return (w << s) | (w >> (64 - s));
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] w, input int s);
    return (w >> s) | (w << (64 - s));
  endfunction

  function automatic logic [63:0] ff(input logic [63:0] w);
    return (rol(w, 1) & rol(w, 8)) ^ rol(w, 2);
  endfunction

  task automatic build_keys(input logic [255:0] key);
    bit [0:61]   z4;
    logic [63:0] tmp;
    z4 = 62'b1101000111_1001101011_0110001000_0001011100_0011001010_0100111011_11;
    for (int i = 0; i < 4; i++) rk[i] = key[64*i +: 64];
    for (int i = 4; i < 72; i++) begin
      tmp   = ror(rk[i-1], 3) ^ rk[i-3];
      tmp   = tmp ^ ror(tmp, 1);
      rk[i] = 64'hffff_ffff_ffff_fffc ^ {63'b0, z4[(i-4) % 62]} ^ rk[i-4] ^ tmp;
    end
  endtask

  function automatic logic [127:0] enc_ref(input logic [127:0] pt);
    logic [63:0] x, y, t;
    x = pt[127:64];
    y = pt[63:0];
    for (int i = 0; i < 72; i++) begin
      t = x;
      x = y ^ ff(x) ^ rk[i];
      y = t;
    end
    return {x, y};
  endfunction

  function automatic logic [127:0] dec_ref(input logic [127:0] ct);
    logic [63:0] x, y, t;
    x = ct[127:64];
    y = ct[63:0];
    for (int i = 71; i >= 0; i--) begin
      t = y;
      y = x ^ ff(y) ^ rk[i];
      x = t;
    end
    return {x, y};
  endfunction

  // ---------------- subkey memory model, read latency 2 ----------------
  logic        s1_en = 1'b0;
  logic [8:0]  s1_addr = '0;
  logic        bram_vld = 1'b0;
  logic [63:0] bram_data = '0;
  logic        spur_vld = 1'b0;
  logic [63:0] spur_data = '0;

  always @(posedge clk) begin
    s1_en     <= key_rd_en;
    s1_addr   <= key_addr;
    bram_vld  <= s1_en;
    bram_data <= (s1_en && int'(s1_addr) < 72) ? rk[int'(s1_addr)] : 64'h0;
  end

  assign key_data_vld = bram_vld | spur_vld;
  assign key_data     = bram_vld ? bram_data : spur_data;

  // ---------------- scoreboard ----------------
  typedef struct {
    bit           is_abort;
    logic [127:0] blk;
  } exp_t;

  exp_t exp_q[$];
  int   addr_q[$];
  int   acc_cyc = 0;
  int   out_hs_cyc = 0;
  logic ov_prev = 1'b0;
  exp_t mon_e;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic miss(input string nm);
    n_cmp++;
    n_mis++;
    $display("FAIL %s: got no event required event (cycle %0d)", nm, cyc);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) acc_cyc = cyc;
      if (key_rd_en) begin
        if (addr_q.size() == 0) miss("key_addr_unexpected_read");
        else chk("key_addr", 128'(key_addr), 128'(addr_q.pop_front()));
      end
      if (out_valid && !ov_prev) chk("latency", 128'(cyc - acc_cyc), 128'(75));
      if (out_valid && out_ready) begin
        out_hs_cyc = cyc;
        if (exp_q.size() == 0) miss("unexpected_out_valid");
        else begin
          mon_e = exp_q.pop_front();
          chk("out_kind", 128'(0), 128'(mon_e.is_abort));
          chk("out_block", out_block, mon_e.blk);
        end
      end
      if (out_abort) begin
        if (exp_q.size() == 0) miss("unexpected_out_abort");
        else begin
          mon_e = exp_q.pop_front();
          chk("abort_kind", 128'(1), 128'(mon_e.is_abort));
        end
      end
    end
    ov_prev = out_valid;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] blk, input bit dec,
                      input logic [127:0] expect_blk, input bit push_exp);
    bit ok;
    exp_t e;
    if (push_exp) begin
      e.is_abort = 1'b0;
      e.blk      = expect_blk;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 72; i++) addr_q.push_back(dec ? 71 - i : i);
    in_block   = blk;
    in_decrypt = dec;
    in_valid   = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) miss("accept_timeout");
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) miss("drain_timeout");
    tick();
  endtask

  task automatic pulse_full();
    key_mem_full = 1'b1;
    tick();
    key_mem_full = 1'b0;
  endtask

  function automatic logic [127:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] b;
    bit           ok;
    exp_t         e;

    rst = 1'b1;
    in_valid = 1'b0;
    in_decrypt = 1'b0;
    in_block = '0;
    key_mem_full = 1'b0;
    key_compute_start = 1'b0;
    out_ready = 1'b1;
    build_keys(INIT_KEY);
    repeat (3) tick();
    rst = 1'b0;

    // reset values
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_key_rd_en", 128'(key_rd_en), 128'(0));
    chk("rst_key_addr", 128'(key_addr), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_block", out_block, 128'(0));
    chk("rst_out_abort", 128'(out_abort), 128'(0));

    // block offered before the keys exist
    in_block = PT_KAT;
    in_decrypt = 1'b0;
    in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("nokey_in_ready", 128'(in_ready), 128'(0));
      chk("nokey_key_rd_en", 128'(key_rd_en), 128'(0));
    end
    e.is_abort = 1'b0;
    e.blk = CT_KAT;
    exp_q.push_back(e);
    for (int i = 0; i < 72; i++) addr_q.push_back(i);
    tick();
    key_mem_full = 1'b1;
    @(negedge clk);
    chk("full_cycle_in_ready", 128'(in_ready), 128'(0));
    tick();
    key_mem_full = 1'b0;
    @(negedge clk);
    chk("after_full_in_ready", 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    wait_drain(200);

    // known-answer decrypt
    send(CT_KAT, 1'b1, PT_KAT, 1'b1);
    wait_drain(200);

    // backpressure
    out_ready = 1'b0;
    b = rand_blk();
    send(b, 1'b0, enc_ref(b), 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) miss("bp_out_valid_timeout");
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      chk("bp_out_block", out_block, enc_ref(b));
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      @(negedge clk);
    end
    tick();
    out_ready = 1'b1;
    b = rand_blk();
    send(b, 1'b0, enc_ref(b), 1'b1);
    chk("bp_next_accept", 128'(acc_cyc - out_hs_cyc), 128'(1));
    wait_drain(200);

    // abort at round 30
    b = rand_blk();
    send(b, 1'b0, '0, 1'b0);
    repeat (32) tick();
    e.is_abort = 1'b1;
    e.blk = '0;
    exp_q.push_back(e);
    key_compute_start = 1'b1;
    tick();
    key_compute_start = 1'b0;
    addr_q.delete();
    @(negedge clk);
    chk("abort_pulse", 128'(out_abort), 128'(1));
    chk("abort_in_ready", 128'(in_ready), 128'(0));
    tick();
    @(negedge clk);
    chk("abort_one_cycle", 128'(out_abort), 128'(0));
    chk("abort_no_out_valid", 128'(out_valid), 128'(0));
    repeat (3) begin
      tick();
      @(negedge clk);
      chk("abort_keys_invalid", 128'(in_ready), 128'(0));
    end
    tick();
    pulse_full();
    b = rand_blk();
    send(b, 1'b1, dec_ref(b), 1'b1);
    wait_drain(200);

    // reset in the middle of a block
    b = rand_blk();
    send(b, 1'b0, '0, 1'b0);
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    addr_q.delete();
    @(negedge clk);
    chk("midrst_in_ready", 128'(in_ready), 128'(0));
    chk("midrst_key_rd_en", 128'(key_rd_en), 128'(0));
    chk("midrst_key_addr", 128'(key_addr), 128'(0));
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_out_block", out_block, 128'(0));
    chk("midrst_out_abort", 128'(out_abort), 128'(0));

    // stray key_data_vld while idle
    tick();
    spur_vld = 1'b1;
    repeat (3) begin
      spur_data = {$urandom, $urandom};
      @(negedge clk);
      chk("spur_in_ready", 128'(in_ready), 128'(0));
      chk("spur_out_valid", 128'(out_valid), 128'(0));
      chk("spur_key_rd_en", 128'(key_rd_en), 128'(0));
      tick();
    end
    pulse_full();
    repeat (2) begin
      spur_data = {$urandom, $urandom};
      @(negedge clk);
      chk("spur_idle_ready", 128'(in_ready), 128'(1));
      tick();
    end
    spur_vld = 1'b0;

    // back-to-back blocks, alternating mode
    for (int i = 0; i < 6; i++) begin
      b = rand_blk();
      if (i % 2 == 1) send(b, 1'b1, dec_ref(b), 1'b1);
      else send(b, 1'b0, enc_ref(b), 1'b1);
    end
    wait_drain(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

endmodule
